mem_wrr_arbiter: RTL
====================

MEM_WRR_ARBITER -- requirements
Module: mem_wrr_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 16, number of requesters; power of 2, at least 2.
REQ-002 SHALL have parameter LEN_W, default 4, width of per-port burst length field.
REQ-003 SHALL have parameter WGT_W, default 3, width of per-port weight field.
REQ-004 SHALL have clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have req  in  PORTS  per-port request, level, held until granted burst ends.
REQ-007 SHALL have req_len  in  PORTS*LEN_W  per-port burst length minus one; port i occupies bits [i*LEN_W +: LEN_W].
REQ-008 SHALL have req_wgt  in  PORTS*WGT_W  per-port weight minus one; present only when MEM_ARB_WEIGHTS_EN is defined.
REQ-009 SHALL have beat_ack  in  1  memory accepted one beat of the current grant this cycle.
REQ-010 SHALL have gnt  out  PORTS  registered one-hot grant; all-zero when idle.
REQ-011 SHALL have gnt_id  out  $clog2(PORTS)  binary index of granted port; 0 when idle.
REQ-012 SHALL have gnt_last  out  1  high while the remaining beat count is zero (next beat_ack ends the burst).

Function
REQ-013 SHALL use FSM states IDLE and BURST, encoded in the shared package.
REQ-014 SHALL keep a priority pointer ptr; the search order is ptr, ptr+1, ... wrapping modulo PORTS.
REQ-015 SHALL, in IDLE with any req bit set, grant the first requester in search order at the next edge and enter BURST.
REQ-016 SHALL load beat counter with req_len of the winner at grant; each beat_ack decrements it.
REQ-017 SHALL hold gnt and gnt_id constant throughout BURST.
REQ-018 SHALL end the burst on beat_ack while beat counter is 0; same edge: re-arbitrate with ptr=winner+1 (mod PORTS) and grant the next requester with zero idle cycles, else return to IDLE.
REQ-019 SHALL end the burst early if the granted port drops req while beat_ack is low; same edge behaviour as REQ-018.
REQ-020 SHALL ignore beat_ack in IDLE.
REQ-021 SHALL not advance ptr unless a burst ends (no free-running rotation).
REQ-022 SHALL wrap ptr from PORTS-1 to 0.
REQ-023 SHALL ignore req changes of non-granted ports during BURST; they are sampled only at arbitration.

Reset
REQ-024 SHALL on rst_n low asynchronously force: state IDLE, ptr 0, gnt 0, gnt_id 0, gnt_last 0, beat and credit counters 0.
REQ-025 SHALL abort any burst in progress on reset; first grant after reset favours port 0.

Configuration
REQ-026 SHALL, with MEM_ARB_WEIGHTS_EN defined, load a credit counter with req_wgt of the winner at a fresh grant; at burst end, if credit > 0 and winner still requests, regrant the same port (credit-1, ptr unchanged, new req_len loaded) with zero idle cycles.
REQ-027 SHALL, without MEM_ARB_WEIGHTS_EN, omit req_wgt and the credit counter; every port behaves as weight 1.

Structure
REQ-028 SHALL place the FSM state enum and a clog2-derived index width constant helper in package mem_arb_pkg.
REQ-029 SHALL implement the rotating first-set search as combinational sub-module mem_arb_pick (inputs req, ptr; outputs one-hot, index, any).

Verification (PORTS=4, LEN_W=4, WGT_W=3)
REQ-030 SHALL check: reset, req=4'b1111, all req_len=0, beat_ack held high -> gnt 0001,0010,0100,1000,0001 on consecutive cycles, no gaps.
REQ-031 SHALL check: req=4'b0100 only, req_len[2]=3, beat_ack every cycle -> gnt 0100 for 4 cycles, gnt_last on 4th, then IDLE, ptr=3.
REQ-032 SHALL check: port 1 granted with req_len=5, drops req after 2 beats -> grant released next edge, next requester after port 1 granted.
REQ-033 SHALL check: rst_n low mid-burst (port 2, 3 beats left) -> gnt 0 immediately without clock, next grant to lowest requester from port 0.
REQ-034 SHALL check (MEM_ARB_WEIGHTS_EN): req=4'b0011, req_wgt[0]=2, req_wgt[1]=0, len 0 -> gnt pattern 0001,0001,0001,0010 repeating.
REQ-035 SHALL check: beat_ack pulses in IDLE with req=0 -> gnt stays 0, ptr unchanged.

Source files
------------

// File: rtl/mem_wrr_arbiter_pkg.sv
// Shared types and helpers for the memory weighted round-robin arbiter.
package mem_arb_pkg;

  // Arbiter control state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of a binary index for n items (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_wrr_arbiter_if.sv
// Requester/arbiter bus for mem_wrr_arbiter.
// The per-port weight field req_wgt exists only when MEM_ARB_WEIGHTS_EN is defined.
interface mem_wrr_arbiter_if #(
  parameter int PORTS = 16,
  parameter int LEN_W = 4,
  parameter int WGT_W = 3
);
  import mem_arb_pkg::*;

  localparam int IW = idx_w(PORTS);

  logic [PORTS-1:0]       req;
  logic [PORTS*LEN_W-1:0] req_len;
`ifdef MEM_ARB_WEIGHTS_EN
  logic [PORTS*WGT_W-1:0] req_wgt;
`endif
  logic                   beat_ack;
  logic [PORTS-1:0]       gnt;
  logic [IW-1:0]          gnt_id;
  logic                   gnt_last;

  if (WGT_W < 1) begin : g_bad_wgt
    $error("mem_wrr_arbiter_if: WGT_W must be at least 1");
  end

`ifdef MEM_ARB_WEIGHTS_EN
  modport master (output req, req_len, req_wgt, beat_ack, input gnt, gnt_id, gnt_last);
  modport slave  (input req, req_len, req_wgt, beat_ack, output gnt, gnt_id, gnt_last);
`else
  modport master (output req, req_len, beat_ack, input gnt, gnt_id, gnt_last);
  modport slave  (input req, req_len, beat_ack, output gnt, gnt_id, gnt_last);
`endif

endinterface

// File: rtl/mem_wrr_arbiter_pick.sv
// Rotating first-set search: finds the first set req bit starting at ptr,
// wrapping modulo PORTS (PORTS is a power of two, so index arithmetic wraps).
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int PORTS = 16,
  parameter int IW    = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [PORTS-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW-1:0] cand_s;

  // Walk the ports in priority order and latch the first requester.
  always_comb begin
    any    = 1'b0;
    idx    = IW'(0);
    cand_s = IW'(0);
    for (int i = 0; i < PORTS; i++) begin
      cand_s = ptr + IW'(i);
      if (!any && req[cand_s]) begin
        any = 1'b1;
        idx = cand_s;
      end else begin
        any = any;
      end
    end
  end

  assign onehot = any ? (PORTS'(1) << idx) : PORTS'(0);

endmodule

// File: rtl/mem_wrr_arbiter.sv
// Memory burst arbiter: round-robin grant of whole bursts with a rotating
// priority pointer that only advances when a burst ends.
// Optional feature macro: MEM_ARB_WEIGHTS_EN (per-port weight = consecutive
// bursts a winner may take before the pointer moves on).
module mem_wrr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PORTS = 16,
  parameter int LEN_W = 4,
  parameter int WGT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  mem_wrr_arbiter_if.slave bus
);

  localparam int IW = idx_w(PORTS);

  if ((PORTS < 2) || ((PORTS & (PORTS - 1)) != 0) || (LEN_W < 1) || (WGT_W < 1)) begin : g_bad_cfg
    $error("mem_wrr_arbiter: PORTS must be a power of 2 >= 2, LEN_W and WGT_W >= 1");
  end

  arb_state_e       state_r, state_s;
  logic [IW-1:0]    ptr_r, ptr_s;
  logic [PORTS-1:0] gnt_r, gnt_s;
  logic [IW-1:0]    gnt_id_r, gnt_id_s;
  logic             gnt_last_r, gnt_last_s;
  logic [LEN_W-1:0] beat_r, beat_s;

  logic [IW-1:0]    pick_ptr_s;
  logic [PORTS-1:0] pick_oh_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic [LEN_W-1:0] win_len_s;
  logic [LEN_W-1:0] cur_len_s;
  logic             cur_req_s;
  logic             burst_end_s;
  logic             regrant_s;

`ifdef MEM_ARB_WEIGHTS_EN
  logic [WGT_W-1:0] credit_r, credit_s;
  logic [WGT_W-1:0] win_wgt_s;
`endif

  // While bursting, the only arbitration is at burst end, starting after the winner.
  assign pick_ptr_s = (state_r == BURST) ? (gnt_id_r + IW'(1)) : ptr_r;

  mem_arb_pick #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr_s),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign win_len_s   = bus.req_len[pick_idx_s*LEN_W +: LEN_W];
  assign cur_len_s   = bus.req_len[gnt_id_r*LEN_W +: LEN_W];
  assign cur_req_s   = bus.req[gnt_id_r];
  // Normal end on the last beat, or early end when the owner withdraws with no beat pending.
  assign burst_end_s = (state_r == BURST) &&
                       ((bus.beat_ack && (beat_r == LEN_W'(0))) ||
                        (!bus.beat_ack && !cur_req_s));

`ifdef MEM_ARB_WEIGHTS_EN
  assign win_wgt_s = bus.req_wgt[pick_idx_s*WGT_W +: WGT_W];
  assign regrant_s = burst_end_s && (credit_r != WGT_W'(0)) && cur_req_s;
`else
  assign regrant_s = 1'b0;
`endif

  // Next-state, grant and counter computation.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    gnt_s    = gnt_r;
    gnt_id_s = gnt_id_r;
    beat_s   = beat_r;
`ifdef MEM_ARB_WEIGHTS_EN
    credit_s = credit_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s  = BURST;
          gnt_s    = pick_oh_s;
          gnt_id_s = pick_idx_s;
          beat_s   = win_len_s;
`ifdef MEM_ARB_WEIGHTS_EN
          credit_s = win_wgt_s;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (regrant_s) begin
          // Same owner keeps the bus; pointer stays put.
          beat_s = cur_len_s;
`ifdef MEM_ARB_WEIGHTS_EN
          credit_s = credit_r - WGT_W'(1);
`endif
        end else if (burst_end_s) begin
          ptr_s = gnt_id_r + IW'(1);
          if (pick_any_s) begin
            state_s  = BURST;
            gnt_s    = pick_oh_s;
            gnt_id_s = pick_idx_s;
            beat_s   = win_len_s;
`ifdef MEM_ARB_WEIGHTS_EN
            credit_s = win_wgt_s;
`endif
          end else begin
            state_s  = IDLE;
            gnt_s    = PORTS'(0);
            gnt_id_s = IW'(0);
            beat_s   = LEN_W'(0);
`ifdef MEM_ARB_WEIGHTS_EN
            credit_s = WGT_W'(0);
`endif
          end
        end else if (bus.beat_ack) begin
          beat_s = beat_r - LEN_W'(1);
        end else begin
          beat_s = beat_r;
        end
      end
      default: begin
        state_s  = IDLE;
        ptr_s    = IW'(0);
        gnt_s    = PORTS'(0);
        gnt_id_s = IW'(0);
        beat_s   = LEN_W'(0);
`ifdef MEM_ARB_WEIGHTS_EN
        credit_s = WGT_W'(0);
`endif
      end
    endcase
    gnt_last_s = (state_s == BURST) && (beat_s == LEN_W'(0));
  end

  // State, pointer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= IW'(0);
      gnt_r      <= PORTS'(0);
      gnt_id_r   <= IW'(0);
      gnt_last_r <= 1'b0;
      beat_r     <= LEN_W'(0);
`ifdef MEM_ARB_WEIGHTS_EN
      credit_r   <= WGT_W'(0);
`endif
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      gnt_r      <= gnt_s;
      gnt_id_r   <= gnt_id_s;
      gnt_last_r <= gnt_last_s;
      beat_r     <= beat_s;
`ifdef MEM_ARB_WEIGHTS_EN
      credit_r   <= credit_s;
`endif
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.gnt_id   = gnt_id_r;
  assign bus.gnt_last = gnt_last_r;

endmodule
